muldiv_sequencer: RTL



---
 rtl/muldiv_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit beside the EX-stage ALU.
// Shift-add multiply and restoring divide, one bit per cycle, on operand
// magnitudes; the sign is applied in a final fix-up cycle.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      EX-stage instruction valid
//   aluop      control-unit op; M-group when aluop[4:3] == 2'b01
//   operand_a  rs1 (multiplicand / dividend)
//   operand_b  rs2 (multiplier / divisor)
//   flush      kills any operation in flight
//   stall      holds IF/ID/EX while the unit is busy (combinational)
//   done       one-cycle pulse, result valid
//   result     product half, quotient or remainder; held until next write
//
// Optional: define MULDIV_EARLY_OUT_EN to finish zero-operand cases in two cycles.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [4:0]      aluop,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_FIX, S_FAST, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t           state;
  logic [2:0]       op;
  logic             neg_res;
  logic [XLEN-1:0]  mag_a, mag_b;
  logic [XLEN-1:0]  acc_hi, acc_lo;
  logic [CNT_W-1:0] cnt;

  function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v,
                                              input logic is_signed);
    // MIN_NEG maps onto itself, which is its correct unsigned magnitude.
    return (is_signed && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
  endfunction

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return ~v + (2*XLEN)'(1);
  endfunction

  logic            is_m, accept, a_signed, b_signed, neg_in;
  logic            div_zero, div_ovf, early_zero, take_fast;
  logic [XLEN-1:0] a_mag_in, b_mag_in, fast_val;

  always_comb begin
    is_m     = (aluop[4:3] == 2'b01);
    accept   = start && is_m && !flush && (state == S_IDLE || state == S_DONE);
    stall    = accept || (!flush && (state == S_CALC || state == S_FIX || state == S_FAST));
    // MUL/MULH: both signed; MULHSU: a only; MULHU: none; DIV/REM: both; DIVU/REMU: none.
    a_signed = aluop[2] ? !aluop[0] : (aluop[1:0] != 2'b11);
    b_signed = aluop[2] ? !aluop[0] : !aluop[1];
    a_mag_in = abs_val(operand_a, a_signed);
    b_mag_in = abs_val(operand_b, b_signed);
    // Remainder takes the dividend's sign only; everything else XORs both signs.
    neg_in   = (a_signed && operand_a[XLEN-1]) ^
               (b_signed && operand_b[XLEN-1] && !(aluop[2] && aluop[1]));
    div_zero = aluop[2] && (operand_b == '0);
    div_ovf  = aluop[2] && !aluop[0] && (operand_a == MIN_NEG) && (operand_b == '1);
`ifdef MULDIV_EARLY_OUT_EN
    early_zero = aluop[2] ? (operand_a == '0) : (operand_a == '0 || operand_b == '0);
`else
    early_zero = 1'b0;
`endif
    take_fast = div_zero || div_ovf || early_zero;
    // Divide-by-zero outranks the early-out zero result.
    if (div_zero)     fast_val = aluop[1] ? operand_a : '1;
    else if (div_ovf) fast_val = aluop[1] ? '0 : MIN_NEG;
    else              fast_val = '0;
  end

  logic [XLEN:0]     mul_sum, rem_sh;
  logic [XLEN-1:0]   sub_val, div_res, fix_val;
  logic              sub_ok;
  logic [2*XLEN-1:0] prod_s;

  always_comb begin
    // Multiply: acc_hi accumulates, acc_lo holds the multiplier and collects product LSBs.
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);
    // Divide: acc_hi is the partial remainder, acc_lo shifts the dividend out and quotient in.
    rem_sh  = {acc_hi, acc_lo[XLEN-1]};
    sub_ok  = (rem_sh >= {1'b0, mag_b});
    // When sub_ok the difference is below the divisor, so the low XLEN bits are exact.
    sub_val = rem_sh[XLEN-1:0] - mag_b;
    prod_s  = neg_res ? neg_2x({acc_hi, acc_lo}) : {acc_hi, acc_lo};
    div_res = op[1] ? acc_hi : acc_lo;
    if (!op[2]) fix_val = (op[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    else        fix_val = neg_res ? neg_x(div_res) : div_res;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      op      <= '0;
      neg_res <= 1'b0;
      mag_a   <= '0;
      mag_b   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (accept) begin
              op      <= aluop[2:0];
              mag_a   <= a_mag_in;
              mag_b   <= b_mag_in;
              neg_res <= neg_in;
              cnt     <= '0;
              acc_hi  <= '0;
              if (take_fast) begin
                acc_lo <= fast_val;
                state  <= S_FAST;
              end else begin
                acc_lo <= aluop[2] ? a_mag_in : b_mag_in;
                state  <= S_CALC;
              end
            end else begin
              state <= S_IDLE;
            end
          end
          S_CALC: begin
            if (!op[2]) begin
              acc_hi <= mul_sum[XLEN:1];
              acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
            end else if (sub_ok) begin
              acc_hi <= sub_val;
              acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
            end else begin
              acc_hi <= rem_sh[XLEN-1:0];
              acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(XLEN - 1)) state <= S_FIX;
          end
          S_FIX: begin
            result <= fix_val;
            done   <= 1'b1;
            state  <= S_DONE;
          end
          S_FAST: begin
            result <= acc_lo;
            done   <= 1'b1;
            state  <= S_DONE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
